// File: rtl/operand_stage.sv
// operand_stage: registered decode->execute operand stage.
// Selects srca/srcb from regfile/PC/immediate/constants, resolves RAW hazards
// over NUM_FWD bypass channels (index 0 = youngest), stalls on load-use and
// holds the result in a one-entry valid/ready register.
module operand_stage #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 2,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [1:0]              in_asel,
  input  logic [1:0]              in_bsel,
  input  logic [RA_W-1:0]         in_rs1,
  input  logic [RA_W-1:0]         in_rs2,
  input  logic [XLEN-1:0]         in_rd1,
  input  logic [XLEN-1:0]         in_rd2,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_srca,
  output logic [XLEN-1:0]         out_srcb,
  output logic [XLEN-1:0]         out_rs2val,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_pend, rs2_pend;
  logic [XLEN-1:0] srca_sel, srcb_sel;
  logic            hazard;
  logic            accept;

  // Bypass: scan oldest to youngest so the lowest matching channel wins; x0 is hardwired to zero.
  always_comb begin
    rs1_val  = in_rd1;
    rs2_val  = in_rd2;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_rd[k*RA_W +: RA_W] == in_rs1)) begin
        rs1_val  = fwd_data[k*XLEN +: XLEN];
        rs1_pend = fwd_pending[k];
      end
      if (fwd_valid[k] && (fwd_rd[k*RA_W +: RA_W] == in_rs2)) begin
        rs2_val  = fwd_data[k*XLEN +: XLEN];
        rs2_pend = fwd_pending[k];
      end
    end
    if (in_rs1 == '0) begin
      rs1_val  = '0;
      rs1_pend = 1'b0;
    end
    if (in_rs2 == '0) begin
      rs2_val  = '0;
      rs2_pend = 1'b0;
    end
  end

  // Operand muxes driven by the explicit select codes.
  always_comb begin
    srca_sel = '0;
    srcb_sel = '0;
    case (in_asel)
      2'b00:   srca_sel = rs1_val;
      2'b01:   srca_sel = in_pc;
      2'b10:   srca_sel = in_imm;
      default: srca_sel = '0;
    endcase
    case (in_bsel)
      2'b00:   srcb_sel = rs2_val;
      2'b01:   srcb_sel = in_imm;
      2'b10:   srcb_sel = XLEN'(4);
      default: srcb_sel = '0;
    endcase
  end

  // rs2 is always treated as in use (store data / branch compare), so it stalls regardless of bsel.
  assign hazard    = in_valid & (((in_asel == 2'b00) & rs1_pend) | rs2_pend);
  assign out_valid = (state_reg == FULL);
  assign in_ready  = reset & ~hazard & ~flush & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  // State register for the one-entry buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next-state: flush wins, then accept fills, then a consume with no accept drains.
  always_comb begin
    state_next = state_reg;
    if (flush)                      state_next = EMPTY;
    else if (accept)                state_next = FULL;
    else if (out_valid & out_ready) state_next = EMPTY;
  end

  // Payload registers load only on accept, so a held entry stays bit-exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pc     <= '0;
      out_srca   <= '0;
      out_srcb   <= '0;
      out_rs2val <= '0;
    end else if (accept) begin
      out_pc     <= in_pc;
      out_srca   <= srca_sel;
      out_srcb   <= srcb_sel;
      out_rs2val <= rs2_val;
    end
  end

  // Load-use stall counter; wraps naturally at full scale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              stall_cnt <= '0;
    else if (hazard & ~flush) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: table vectors, hand-written corner sequences and random
// stimulus, all checked against a behavioural model of the operand stage.
module tb_operand_stage;
  localparam int XLEN = 64, NUM_FWD = 2, RA_W = 5, CNT_W = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid, in_ready;
  logic [XLEN-1:0]         in_pc, in_rd1, in_rd2, in_imm;
  logic [1:0]              in_asel, in_bsel;
  logic [RA_W-1:0]         in_rs1, in_rs2;
  logic [NUM_FWD-1:0]      fwd_valid, fwd_pending;
  logic [NUM_FWD*RA_W-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    flush, out_valid, out_ready;
  logic [XLEN-1:0]         out_pc, out_srca, out_srcb, out_rs2val;
  logic [CNT_W-1:0]        stall_cnt;

  operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_asel(in_asel), .in_bsel(in_bsel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_imm(in_imm), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_srca(out_srca), .out_srcb(out_srcb), .out_rs2val(out_rs2val),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic            m_valid;
  logic [63:0]     m_pc, m_a, m_b, m_r2;
  logic [31:0]     m_cnt;
  logic            e_ready, e_hazard;
  logic [63:0]     e_a, e_b, e_r2;

  // Source value: x0 is zero; otherwise the youngest live producer naming it, else the regfile.
  function automatic void src_lookup(input logic [4:0] rs, input logic [63:0] rd,
                                     output logic [63:0] val, output logic pend);
    val  = rd;
    pend = 1'b0;
    if (rs == 5'd0) begin
      val = 64'd0;
      return;
    end
    for (int k = 0; k < NUM_FWD; k++) begin
      if (fwd_valid[k] && fwd_rd[k*RA_W +: RA_W] == rs) begin
        val  = fwd_data[k*XLEN +: XLEN];
        pend = fwd_pending[k];
        return;
      end
    end
  endfunction

  task automatic model_eval();
    logic [63:0] v1, v2;
    logic p1, p2;
    src_lookup(in_rs1, in_rd1, v1, p1);
    src_lookup(in_rs2, in_rd2, v2, p2);
    e_hazard = in_valid && ((in_asel == 2'd0 && p1) || p2);
    e_ready  = reset && !e_hazard && !flush && (!m_valid || out_ready);
    case (in_asel)
      2'd0: e_a = v1;
      2'd1: e_a = in_pc;
      2'd2: e_a = in_imm;
      default: e_a = 64'd0;
    endcase
    case (in_bsel)
      2'd0: e_b = v2;
      2'd1: e_b = in_imm;
      2'd2: e_b = 64'd4;
      default: e_b = 64'd0;
    endcase
    e_r2 = v2;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_a = '0; m_b = '0; m_r2 = '0; m_cnt = '0;
  endtask

  // One clock with current inputs: check in_ready before the edge, outputs after.
  task automatic do_cycle(input string tag);
    #1;
    model_eval();
    chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'(e_ready));
    @(posedge clk);
    if (e_hazard && !flush) m_cnt = m_cnt + 32'd1;
    if (flush) m_valid = 1'b0;
    else if (in_valid && e_ready) begin
      m_valid = 1'b1; m_pc = in_pc; m_a = e_a; m_b = e_b; m_r2 = e_r2;
    end else if (out_ready) m_valid = 1'b0;
    #1;
    chk($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(m_valid));
    chk($sformatf("%s.stall_cnt", tag), 64'(stall_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk($sformatf("%s.out_pc", tag), out_pc, m_pc);
      chk($sformatf("%s.out_srca", tag), out_srca, m_a);
      chk($sformatf("%s.out_srcb", tag), out_srcb, m_b);
      chk($sformatf("%s.out_rs2val", tag), out_rs2val, m_r2);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_asel = 0; in_bsel = 0; in_rs1 = 0; in_rs2 = 0;
    in_rd1 = 0; in_rd2 = 0; in_imm = 0; fwd_valid = 0; fwd_pending = 0;
    fwd_rd = 0; fwd_data = 0; flush = 0; out_ready = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  asel, bsel;
    logic [4:0]  rs1, rs2;
    logic [63:0] pc, rd1, rd2, imm;
    logic [1:0]  fv, fp;
    logic [4:0]  r0, r1;
    logic [63:0] d0, d1;
    logic [63:0] ea, eb, er2;
  } vec_t;

  function automatic vec_t mk(
      input logic [1:0] asel, input logic [1:0] bsel, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [63:0] pc, input logic [63:0] rd1, input logic [63:0] rd2, input logic [63:0] imm,
      input logic [1:0] fv, input logic [1:0] fp, input logic [4:0] r0, input logic [4:0] r1,
      input logic [63:0] d0, input logic [63:0] d1,
      input logic [63:0] ea, input logic [63:0] eb, input logic [63:0] er2);
    vec_t v;
    v.asel = asel; v.bsel = bsel; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.rd1 = rd1;
    v.rd2 = rd2; v.imm = imm; v.fv = fv; v.fp = fp; v.r0 = r0; v.r1 = r1;
    v.d0 = d0; v.d1 = d1; v.ea = ea; v.eb = eb; v.er2 = er2;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    logic [31:0] base;
    // ADD x3,x1,x2 with plain regfile data
    vecs[0] = mk(0, 0, 1, 2, 64'h100, 5, 7, 0, 2'b00, 2'b00, 0, 0, 0, 0, 5, 7, 7);
    // both channels match rs1: youngest (channel 0) wins
    vecs[1] = mk(0, 0, 4, 3, 64'h104, 1, 64'h33, 0, 2'b11, 2'b00, 4, 4, 64'h10, 64'h20, 64'h10, 64'h33, 64'h33);
    // x0 sources read zero even with nonzero regfile data and an x0 producer
    vecs[2] = mk(0, 0, 0, 0, 64'h108, 64'h55, 64'h66, 0, 2'b01, 2'b00, 0, 0, 9, 0, 0, 0, 0);
    // JAL: PC and constant four
    vecs[3] = mk(1, 2, 0, 5, 64'h8000_0000, 0, 64'h77, 0, 2'b00, 2'b00, 0, 0, 0, 0, 64'h8000_0000, 4, 64'h77);
    // AUIPC: PC and immediate
    vecs[4] = mk(1, 1, 0, 0, 64'h400, 0, 0, 64'h1000, 2'b00, 2'b00, 0, 0, 0, 0, 64'h400, 64'h1000, 0);
    // immediate on A, zero on B
    vecs[5] = mk(2, 3, 1, 0, 64'h10C, 3, 0, 64'hFFFF_FFFF_FFFF_F800, 2'b00, 2'b00, 0, 0, 0, 0,
                 64'hFFFF_FFFF_FFFF_F800, 0, 0);
    // zero on A, rs2 forwarded from the older channel only
    vecs[6] = mk(3, 0, 1, 7, 64'h110, 3, 8, 0, 2'b11, 2'b00, 8, 7, 64'h1, 64'hBEEF, 0, 64'hBEEF, 64'hBEEF);
    // invalid younger channel is ignored
    vecs[7] = mk(0, 0, 9, 1, 64'h114, 2, 1, 0, 2'b10, 2'b00, 9, 9, 64'h5, 64'h99, 64'h99, 1, 1);
    // pending older producer shadowed by a ready younger one: no stall
    vecs[8] = mk(0, 0, 0, 6, 64'h118, 0, 2, 0, 2'b11, 2'b10, 6, 6, 64'h60, 64'h61, 0, 64'h60, 64'h60);
    // pending rs1 while asel selects PC: rs1 not in use, no stall
    vecs[9] = mk(1, 2, 1, 2, 64'h20, 0, 3, 0, 2'b01, 2'b01, 1, 0, 64'hDD, 0, 64'h20, 4, 3);

    // ---- reset state ----
    idle();
    in_valid = 1;
    reset = 0;
    model_reset();
    #12;
    chk("rst.out_valid", 64'(out_valid), 0);
    chk("rst.in_ready", 64'(in_ready), 0);
    chk("rst.stall_cnt", 64'(stall_cnt), 0);
    chk("rst.out_srca", out_srca, 0);
    chk("rst.out_rs2val", out_rs2val, 0);
    @(negedge clk);
    reset = 1;
    idle();
    @(posedge clk); #1;

    // ---- table vectors ----
    for (int i = 0; i < 10; i++) begin
      idle();
      in_valid = 1; in_asel = vecs[i].asel; in_bsel = vecs[i].bsel;
      in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_pc = vecs[i].pc;
      in_rd1 = vecs[i].rd1; in_rd2 = vecs[i].rd2; in_imm = vecs[i].imm;
      fwd_valid = vecs[i].fv; fwd_pending = vecs[i].fp;
      fwd_rd = {vecs[i].r1, vecs[i].r0}; fwd_data = {vecs[i].d1, vecs[i].d0};
      do_cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid", i), 64'(out_valid), 1);
      chk($sformatf("vec%0d.srca", i), out_srca, vecs[i].ea);
      chk($sformatf("vec%0d.srcb", i), out_srcb, vecs[i].eb);
      chk($sformatf("vec%0d.rs2val", i), out_rs2val, vecs[i].er2);
      $display("vec %0d: srca=0x%0h srcb=0x%0h rs2val=0x%0h", i, out_srca, out_srcb, out_rs2val);
    end

    // ---- load-use stall on rs2 for two cycles ----
    idle();
    in_valid = 1; in_rs1 = 1; in_rd1 = 1; in_rs2 = 6; in_rd2 = 5;
    fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_rd = {5'd0, 5'd6}; fwd_data = {64'd0, 64'hDEAD};
    base = m_cnt;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lu.stall_ready", 64'(in_ready), 0);
      #(-0) do_cycle("lu_stall");
    end
    chk("lu.stall_cnt", 64'(stall_cnt), 64'(base + 32'd2));
    fwd_pending = 2'b00; fwd_data = {64'd0, 64'hAB};
    do_cycle("lu_go");
    chk("lu.srcb", out_srcb, 64'hAB);
    chk("lu.rs2val", out_rs2val, 64'hAB);
    $display("load-use: stall_cnt=%0d srcb=0x%0h", stall_cnt, out_srcb);

    // rs2 pending while bsel selects IMM still stalls
    in_bsel = 2'b01; fwd_pending = 2'b01;
    #1;
    chk("cons.in_ready", 64'(in_ready), 0);
    do_cycle("cons");

    // ---- backpressure ----
    idle();
    in_valid = 1; in_asel = 2; in_bsel = 3; in_imm = 64'h111; in_pc = 64'h200;
    do_cycle("bp_load");
    in_imm = 64'h222; in_pc = 64'h204; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      do_cycle("bp_hold");
      chk("bp.stable_srca", out_srca, 64'h111);
      chk("bp.stable_pc", out_pc, 64'h200);
      chk("bp.ready", 64'(in_ready), 0);
    end
    out_ready = 1;
    do_cycle("bp_b2b");
    chk("bp.b2b_valid", 64'(out_valid), 1);
    chk("bp.b2b_srca", out_srca, 64'h222);
    $display("backpressure: srca=0x%0h valid=%0b", out_srca, out_valid);

    // ---- flush beats hold and accept ----
    out_ready = 0; in_imm = 64'h333; flush = 1;
    do_cycle("flush");
    chk("flush.out_valid", 64'(out_valid), 0);
    flush = 0;

    // ---- async reset mid-hold ----
    in_imm = 64'h444; out_ready = 1;
    do_cycle("pre_rst_load");
    out_ready = 0; in_valid = 0;
    do_cycle("pre_rst_hold");
    #3;
    reset = 0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 0);
    chk("arst.stall_cnt", 64'(stall_cnt), 0);
    chk("arst.out_srca", out_srca, 0);
    chk("arst.out_pc", out_pc, 0);
    chk("arst.in_ready", 64'(in_ready), 0);
    model_reset();
    $display("async reset: out_valid=%0b stall_cnt=%0d", out_valid, stall_cnt);
    @(negedge clk);
    reset = 1;
    idle();
    @(posedge clk); #1;

    // ---- random traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      in_asel     = 2'($urandom_range(0, 3));
      in_bsel     = 2'($urandom_range(0, 3));
      in_rs1      = 5'($urandom_range(0, 3));
      in_rs2      = 5'($urandom_range(0, 3));
      in_pc       = {$urandom, $urandom};
      in_rd1      = {$urandom, $urandom};
      in_rd2      = {$urandom, $urandom};
      in_imm      = {$urandom, $urandom};
      fwd_valid   = 2'($urandom_range(0, 3));
      fwd_pending = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      fwd_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_data    = {$urandom, $urandom, $urandom, $urandom};
      do_cycle($sformatf("rnd%0d", i));
    end
    $display("random: 400 cycles, stall_cnt=%0d", stall_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
